// File: rtl/uart_cmd_responder.sv
// Byte-framed command responder on the host side of the uart FIFOs.
// Parses 'W' addr data / 'R' addr frames, executes against a byte register file, answers ACK/NAK/data.
module uart_cmd_responder #(
    parameter int unsigned NUM_REGS       = 16,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  rx_empty,
    input  logic [7:0]            rx_data,
    output logic                  ld_rx_data,
    input  logic                  tx_full,
    output logic                  ld_tx_data,
    output logic [7:0]            tx_data,
    output logic [NUM_REGS*8-1:0] reg_out,
    output logic [7:0]            err_count,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAP_CMD,
        S_GET_ADDR,
        S_CAP_ADDR,
        S_GET_DATA,
        S_CAP_DATA,
        S_EXEC,
        S_RESP
    } state_t;

    localparam logic [7:0]       CMD_W  = 8'h57;
    localparam logic [7:0]       CMD_R  = 8'h52;
    localparam logic [7:0]       ACK    = 8'h06;
    localparam logic [7:0]       NAK    = 8'h15;
    localparam logic [8:0]       NREGS9 = 9'(NUM_REGS);
    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_q, state_d;
    logic             cmd_w_q, cmd_w_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       resp_q, resp_d;
    logic             nak_q, nak_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [7:0]       err_q, err_d;
    logic             err_inc;
    logic             wr_en;
    logic             armed_q;
    logic             in_range;
    logic [7:0]       rd_byte;
    logic [7:0]       regs_q [NUM_REGS];

    // Full 8-bit address is kept so indices beyond the file are rejected, not aliased.
    assign in_range = {1'b0, addr_q} < NREGS9;
    assign rd_byte  = regs_q[addr_q[ADDR_W-1:0]];

    always_comb begin
        state_d    = state_q;
        cmd_w_d    = cmd_w_q;
        addr_d     = addr_q;
        data_d     = data_q;
        resp_d     = resp_q;
        nak_d      = nak_q;
        tmo_d      = tmo_q;
        err_inc    = 1'b0;
        wr_en      = 1'b0;
        ld_rx_data = 1'b0;
        ld_tx_data = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (armed_q && !rx_empty) begin
                    ld_rx_data = 1'b1;
                    tmo_d      = '0;
                    state_d    = S_CAP_CMD;
                end
            end
            S_CAP_CMD: begin
                if (rx_data == CMD_W || rx_data == CMD_R) begin
                    cmd_w_d = (rx_data == CMD_W);
                    state_d = S_GET_ADDR;
                end else begin
                    resp_d  = NAK;
                    nak_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_GET_ADDR, S_GET_DATA: begin
                // Timeout is checked before the pop so it wins a same-cycle byte arrival.
                if (tmo_q == TMO) begin
                    tmo_d   = '0;
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end else if (!rx_empty) begin
                    ld_rx_data = 1'b1;
                    tmo_d      = '0;
                    state_d    = (state_q == S_GET_ADDR) ? S_CAP_ADDR : S_CAP_DATA;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            S_CAP_ADDR: begin
                addr_d  = rx_data;
                state_d = cmd_w_q ? S_GET_DATA : S_EXEC;
            end
            S_CAP_DATA: begin
                data_d  = rx_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!in_range) begin
                    resp_d = NAK;
                    nak_d  = 1'b1;
                end else if (cmd_w_q) begin
                    wr_en  = 1'b1;
                    resp_d = ACK;
                    nak_d  = 1'b0;
                end else begin
                    resp_d = rd_byte;
                    nak_d  = 1'b0;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (!tx_full) begin
                    ld_tx_data = 1'b1;
                    err_inc    = nak_q;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cmd_w_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            resp_q  <= '0;
            nak_q   <= 1'b0;
            tmo_q   <= '0;
            err_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_w_q <= cmd_w_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            resp_q  <= resp_d;
            nak_q   <= nak_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            armed_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[addr_q[ADDR_W-1:0]] <= data_q;
        end
    end

    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_out[8*i +: 8] = regs_q[i];
        end
    end

    assign tx_data   = ld_tx_data ? resp_q : '0;
    assign err_count = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench: FIFO models around the responder, frame-level reference model and scoreboard.
module tb_uart_cmd_responder;

    localparam int unsigned NREGS = 8;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              rx_empty;
    logic [7:0]        rx_data;
    logic              ld_rx_data;
    logic              tx_full;
    logic              ld_tx_data;
    logic [7:0]        tx_data;
    logic [NREGS*8-1:0] reg_out;
    logic [7:0]        err_count;
    logic              busy;

    uart_cmd_responder #(
        .NUM_REGS       (NREGS),
        .ADDR_W         (3),
        .TIMEOUT_CYCLES (20),
        .CNT_W          (8)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .rx_empty   (rx_empty),
        .rx_data    (rx_data),
        .ld_rx_data (ld_rx_data),
        .tx_full    (tx_full),
        .ld_tx_data (ld_tx_data),
        .tx_data    (tx_data),
        .reg_out    (reg_out),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] mregs [NREGS];
    int         merr;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         first_pop = -1;
    int         last_tx = -1;
    int         tx_seen = 0;
    bit         prev_pop = 0;
    bit         bp_rand = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] mflat();
        logic [63:0] r = '0;
        for (int i = 0; i < NREGS; i++) r[8*i +: 8] = mregs[i];
        return r;
    endfunction

    function automatic void note_nak();
        if (merr < 255) merr++;
    endfunction

    task automatic push(input logic [7:0] b);
        rx_q.push_back(b);
        rx_empty = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        push(8'h57); push(a); push(d);
        if (a < NREGS) begin
            mregs[a] = d;
            exp_q.push_back(8'h06);
        end else begin
            exp_q.push_back(8'h15);
            note_nak();
        end
    endtask

    task automatic do_read(input logic [7:0] a);
        push(8'h52); push(a);
        if (a < NREGS) exp_q.push_back(mregs[a]);
        else begin
            exp_q.push_back(8'h15);
            note_nak();
        end
    endtask

    task automatic do_bad(input logic [7:0] c);
        push(c);
        exp_q.push_back(8'h15);
        note_nak();
    endtask

    // One clock: sample strobes mid-cycle, then apply FIFO side effects after the edge.
    task automatic tick();
        logic       popped;
        logic [7:0] pb;
        logic [7:0] e;
        #1;
        popped = 1'b0;
        pb = 8'h00;
        if (ld_rx_data === 1'b1) begin
            check("pop_legal", {62'd0, rx_q.size() == 0, prev_pop}, 64'd0);
            if (rx_q.size() != 0) pb = rx_q.pop_front();
            popped = 1'b1;
            if (first_pop < 0) first_pop = cyc;
        end
        prev_pop = (ld_rx_data === 1'b1);
        if (ld_tx_data === 1'b1) begin
            tx_seen++;
            last_tx = cyc;
            check("push_while_full", {63'd0, tx_full}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_push", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("tx_byte", {56'd0, tx_data}, {56'd0, e});
            end
        end
        @(posedge clk_i);
        #1;
        cyc++;
        if (popped) rx_data = pb;
        rx_empty = (rx_q.size() == 0);
        if (bp_rand) tx_full = ($urandom_range(0, 3) == 0);
        @(negedge clk_i);
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && rx_q.size() == 0 && busy === 1'b0) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, {63'd0, n < budget}, 64'd1);
    endtask

    initial begin
        logic [7:0] a, d, c;
        int         k, tx0;

        for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
        merr     = 0;
        rst_n_i  = 1'b0;
        rx_empty = 1'b1;
        rx_data  = 8'h00;
        tx_full  = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_ld_rx", {63'd0, ld_rx_data}, 64'd0);
        check("rst_ld_tx", {63'd0, ld_tx_data}, 64'd0);
        check("rst_tx_data", {56'd0, tx_data}, 64'd0);
        check("rst_regs", reg_out, 64'd0);
        check("rst_err", {56'd0, err_count}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (2) tick();

        // Write-then-read with latency
        first_pop = -1;
        do_write(8'd3, 8'hA5);
        wait_quiet("wr3", 100);
        check("lat_write", last_tx - first_pop + 1, 64'd8);
        check("reg3", {56'd0, reg_out[31:24]}, 64'hA5);
        first_pop = -1;
        do_read(8'd3);
        wait_quiet("rd3", 100);
        check("lat_read", last_tx - first_pop + 1, 64'd6);
        check("err_after_rw", {56'd0, err_count}, merr);

        // Unknown command then a normal read
        do_bad(8'h41);
        wait_quiet("bad41", 100);
        check("err_after_bad", {56'd0, err_count}, 64'd1);
        check("busy_after_bad", {63'd0, busy}, 64'd0);
        do_read(8'd0);
        wait_quiet("rd0", 100);

        // Out-of-range write consumes all bytes and changes nothing
        do_write(8'h0A, 8'h11);
        wait_quiet("oor", 100);
        check("oor_regs", reg_out, mflat());
        check("oor_err", {56'd0, err_count}, merr);
        do_write(8'd1, 8'h3C);
        do_read(8'd1);
        wait_quiet("after_oor", 200);
        check("regs_after_oor", reg_out, mflat());

        // Backpressure: hold the response, then exactly one push on release
        tx_full = 1'b1;
        do_read(8'd0);
        tx0 = tx_seen;
        repeat (30) tick();
        check("bp_busy", {63'd0, busy}, 64'd1);
        check("bp_no_push", tx_seen - tx0, 64'd0);
        tx_full = 1'b0;
        tick();
        check("bp_one_push", tx_seen - tx0, 64'd1);
        repeat (5) tick();
        check("bp_still_one", tx_seen - tx0, 64'd1);

        // Timeout: lone 'W' abandons the frame without a response
        tx0 = tx_seen;
        push(8'h57);
        note_nak();
        repeat (15) tick();
        check("tmo_not_early", {63'd0, busy}, 64'd1);
        wait_quiet("tmo", 60);
        check("tmo_no_push", tx_seen - tx0, 64'd0);
        check("tmo_err", {56'd0, err_count}, merr);
        do_bad(8'h06);
        wait_quiet("late_byte", 100);
        check("late_byte_err", {56'd0, err_count}, merr);

        // Saturation of the error counter
        for (int i = 0; i < 260; i++) do_bad(8'h41);
        wait_quiet("sat", 2000);
        check("err_sat", {56'd0, err_count}, 64'd255);
        check("err_sat_model", {56'd0, err_count}, merr);

        // Randomized frames with random TX backpressure
        bp_rand = 1;
        for (int f = 0; f < 60; f++) begin
            k = $urandom_range(0, 2);
            a = 8'($urandom_range(0, 11));
            d = 8'($urandom_range(0, 255));
            c = 8'($urandom_range(0, 255));
            if (c == 8'h57 || c == 8'h52) c = 8'h00;
            case (k)
                0: do_write(a, d);
                1: do_read(a);
                default: do_bad(c);
            endcase
            if (f % 4 == 3) wait_quiet("rand", 600);
        end
        wait_quiet("rand_end", 600);
        bp_rand = 0;
        tx_full = 1'b0;
        tick();
        check("rand_regs", reg_out, mflat());
        check("rand_err", {56'd0, err_count}, merr);

        // Reset in the middle of a write frame
        tx0 = tx_seen;
        push(8'h57); push(8'h05);
        repeat (4) tick();
        rst_n_i = 1'b0;
        #1;
        for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
        merr = 0;
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_regs", reg_out, 64'd0);
        check("mid_rst_err", {56'd0, err_count}, 64'd0);
        repeat (2) tick();
        rst_n_i = 1'b1;
        repeat (2) tick();
        check("mid_rst_no_push", tx_seen - tx0, 64'd0);
        do_read(8'd5);
        wait_quiet("post_rst", 100);
        check("post_rst_regs", reg_out, 64'd0);
        check("post_rst_pushes", tx_seen - tx0, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
Processor-side command responder that sits on the host end of the uart block's byte interface. It drains the RX FIFO, parses a small byte-framed command protocol from the remote initiator, executes reads and writes against an internal byte register file, and pushes response bytes into the TX FIFO. It turns the uart into a remotely accessible register port without a host processor.

Parameters:
NUM_REGS, 16, number of 8-bit registers (2..256).
ADDR_W, 4, register index width; must equal ceil(log2(NUM_REGS)).
TIMEOUT_CYCLES, 50000, maximum clk_i cycles allowed between bytes inside one frame (1 ms at 50 MHz).
CNT_W, 16, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
clk_i  in  1  system clock, same as uart clk_i.
rst_n_i  in  1  asynchronous active-low reset.
rx_empty  in  1  uart RX FIFO empty.
rx_data  in  8  uart RX byte; valid in the cycle after ld_rx_data.
ld_rx_data  out  1  one-cycle pop strobe to the uart RX FIFO.
tx_full  in  1  uart TX FIFO full.
ld_tx_data  out  1  one-cycle push strobe to the uart TX FIFO.
tx_data  out  8  TX byte; valid in the same cycle as ld_tx_data.
reg_out  out  NUM_REGS*8  flattened register file; reg i sits at bits [8i+7:8i].
err_count  out  8  saturating count of NAKs plus timeouts.
busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: ld_rx_data=0, ld_tx_data=0, tx_data=0x00, all registers 0x00, err_count=0, busy=0, state=IDLE.
- Reset is asynchronous. Asserting reset mid-frame or mid-response aborts immediately; no partial push follows.
- Frames:
  - Write: 0x57 ('W'), addr, data.
  - Read: 0x52 ('R'), addr.
- Responses:
  - Write OK: 0x06 (ACK).
  - Read OK: the register byte.
  - Any error: 0x15 (NAK).
- Pop rule:
  - ld_rx_data is asserted for exactly one cycle, and only in IDLE, GET_ADDR or GET_DATA with rx_empty=0.
  - The next state (CAP_*) samples rx_data.
  - Never pop while rx_empty=1, and never pop on two consecutive cycles.
- States:
  - IDLE: pop if rx_empty=0, then go to CAP_CMD.
  - CAP_CMD:
    - 0x57 or 0x52: latch cmd, go to GET_ADDR.
    - Any other byte: resp=NAK, go to RESP.
  - GET_ADDR: pop if rx_empty=0, then go to CAP_ADDR. Otherwise run the timeout counter.
  - CAP_ADDR: latch addr.
    - cmd=W: go to GET_DATA.
    - cmd=R: go to EXEC.
  - GET_DATA: pop if rx_empty=0, then go to CAP_DATA. Otherwise run the timeout counter.
  - CAP_DATA: latch data, go to EXEC.
  - EXEC:
    - addr >= NUM_REGS: resp=NAK. No write occurs; for W the data byte has already been consumed.
    - W: reg[addr]<=data, resp=ACK.
    - R: resp=reg[addr], the value before any same-cycle update.
    - Always go to RESP.
  - RESP:
    - tx_full=0: ld_tx_data=1 for one cycle with tx_data=resp, go to IDLE.
    - tx_full=1: hold, with no push and no timeout.
- Latency with bytes already in the RX FIFO and TX not full:
  - W frame: 8 cycles from the first pop to the ACK push.
  - R frame: 6 cycles from the first pop to the data push.
- Timeout:
  - The counter clears on every pop and increments each cycle spent in GET_ADDR or GET_DATA.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, send no response, err_count+1.
  - A frame byte arriving later is parsed as a new command byte.
- err_count increments on every NAK push and every timeout, and saturates at 0xFF.
- reg_out is registered. A write is visible on reg_out the cycle after EXEC.
- Simultaneous events:
  - The RX FIFO becoming non-empty in the same cycle the timeout fires: the timeout wins, and the byte is popped from IDLE next cycle.
  - A byte arriving during RESP stays in the FIFO until IDLE.

Test Plan:
- Write-then-read: push 57 03 A5, then 52 03 -> TX receives 06, then A5; reg_out[31:24]=A5; err_count=0.
- Unknown command: push 0x41 -> TX 15; err_count=1; state returns to IDLE; a following 52 00 returns 00.
- Out-of-range with NUM_REGS=8: push 57 0A 11 -> TX 15; all three bytes consumed; no register changes; next frame parses correctly.
- Backpressure: hold tx_full=1 while 52 00 completes -> ld_tx_data stays 0 indefinitely; release -> exactly one push of 00 on the next cycle.
- Timeout with TIMEOUT_CYCLES=20: push 57, then nothing for 25 cycles -> no TX push, err_count=1, busy=0. A later 06 byte is treated as a command and NAKed.
- Reset mid-frame: push 57 05, drop rst_n_i for 2 cycles, then push 52 05 -> TX 00, regs all 0, no stray push during or after reset.
